// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_SYNC_STAGES = 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } ps2_state_t;

    // PS/2 uses odd parity across the data byte and the parity bit.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO for received scan codes; head is read combinationally at the read pointer.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             do_rd;
    logic             do_wr;

    // The extra pointer MSB separates the full and empty cases.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mem[0] <= '0;
        end else if (do_wr) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 receiver: pin synchronisers, 11-bit frame deserialiser with timeout, and a scan-code FIFO.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       sampling,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_DATA_BITS);
    localparam int S  = PS2_SYNC_STAGES;

    logic [S-1:0]             clk_sync_reg;
    logic [S-1:0]             data_sync_reg;
    logic                     sampling_reg;
    logic                     bit_reg;
    ps2_state_t               state_reg;
    logic [BW-1:0]            bit_cnt_reg;
    logic [PS2_DATA_BITS-1:0] shreg_reg;
    logic                     par_reg;
    logic [TW-1:0]            to_cnt_reg;
    logic                     overflow_reg;

    logic fall;
    logic timeout_hit;
    logic frame_ok;
    logic wr_en;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    always_ff @(posedge clk) begin
        if (clr) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
            sampling_reg  <= 1'b0;
            bit_reg       <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[S-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[S-2:0], ps2_data};
            sampling_reg  <= fall;
            bit_reg       <= data_sync_reg[S-2];
        end
    end

    // The edge and its data bit are registered together so the FSM sees them in one cycle.
    assign fall        = clk_sync_reg[S-1] & ~clk_sync_reg[S-2];
    assign timeout_hit = (state_reg != IDLE) && !sampling_reg &&
                         (to_cnt_reg == TW'(TIMEOUT_CYCLES));
    assign frame_ok    = bit_reg && odd_parity_ok(shreg_reg, par_reg);
    assign wr_en       = sampling_reg && (state_reg == STOP) && frame_ok;
    assign frame_err   = (sampling_reg && (state_reg == IDLE) && bit_reg) ||
                         (sampling_reg && (state_reg == STOP) && !frame_ok) ||
                         timeout_hit;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
            par_reg     <= 1'b0;
            to_cnt_reg  <= '0;
        end else begin
            if (state_reg == IDLE || sampling_reg || timeout_hit) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + TW'(1);
            end

            if (timeout_hit) begin
                state_reg <= IDLE;
            end else if (sampling_reg) begin
                case (state_reg)
                    IDLE: begin
                        if (!bit_reg) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shreg_reg   <= {bit_reg, shreg_reg[PS2_DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + BW'(1);
                        if (bit_cnt_reg == BW'(PS2_DATA_BITS - 1)) state_reg <= PAR;
                    end
                    PAR: begin
                        par_reg   <= bit_reg;
                        state_reg <= STOP;
                    end
                    STOP:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign pop = !nextdata_n && !fifo_empty;

    // A good frame is lost only when the FIFO is full and nothing is popped that cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            overflow_reg <= 1'b0;
        end else if (wr_en && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end else if (pop) begin
            overflow_reg <= 1'b0;
        end
    end

    ps2_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (PS2_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .srst    (clr),
        .wr_en   (wr_en),
        .wr_data (shreg_reg),
        .rd_en   (!nextdata_n),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (data)
    );

    assign ready    = !fifo_empty;
    assign overflow = overflow_reg;
    assign sampling = sampling_reg;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Random and directed PS/2 frames checked against a queue-based model of the received byte stream.
module tb_ps2_frame_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 300;
    localparam int HALF  = 40;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       sampling;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_frame_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .sampling   (sampling),
        .frame_err  (frame_err)
    );

    int         chk_cnt = 0;
    int         pass_cnt = 0;
    logic [7:0] exp_q[$];
    int         err_exp = 0;
    int         err_seen = 0;
    bit         ovf_exp = 0;
    bit         consume_en = 0;
    bit         blind_pop = 0;
    int         pop_req = 0;
    int         samp_cnt = 0;
    int         pop_at_samp = 0;
    int         watch_samp = 0;
    bit         t1_pending = 0;
    logic       rdy_t = 1'b0;
    logic       rdy_t1 = 1'b0;
    logic [7:0] data_t1 = 8'h00;
    logic       err_samp = 1'b0;
    int         lat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: counts edges and errors, and pops/compares FIFO output against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            nextdata_n = 1'b1;
            if (!clr) begin
                if (t1_pending) begin
                    rdy_t1 = ready;
                    data_t1 = data;
                    t1_pending = 0;
                end
                if (sampling) samp_cnt++;
                if (sampling && samp_cnt == watch_samp) begin
                    rdy_t = ready;
                    t1_pending = 1;
                end
                if (frame_err) begin
                    err_seen++;
                    err_samp = sampling;
                end
                if (ready && (consume_en || pop_req > 0 ||
                              (pop_at_samp != 0 && sampling && samp_cnt == pop_at_samp))) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL pop_extra: got %02h, expected no entry", data);
                    end else begin
                        check("pop_data", data, exp_q.pop_front());
                    end
                    $display("pop %02h", data);
                    nextdata_n = 1'b0;
                    ovf_exp = 0;
                    if (pop_req > 0) pop_req--;
                end else if (blind_pop && !ready) begin
                    nextdata_n = 1'b0;
                    blind_pop = 0;
                end
            end
        end
    end

    task automatic ps2_send(input logic [10:0] bits, input int nbits);
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (i == 0 && sampling && lat == 0) lat = k;
            end
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    // Reference model: a good frame joins the queue unless the FIFO would be full with no pop.
    task automatic send_byte(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit coincide);
        logic [10:0] f;
        logic        p;
        p = (~^d) ^ bad_par;
        f = {~bad_stop, p, d, 1'b0};
        if (bad_par || bad_stop) err_exp++;
        else if (consume_en || coincide || exp_q.size() < DEPTH) exp_q.push_back(d);
        else ovf_exp = 1;
        $display("send %02h par_err=%0d stop_err=%0d", d, bad_par, bad_stop);
        ps2_send(f, 11);
    endtask

    task automatic pop_n(input int n);
        pop_req = n;
        for (int c = 0; c < 1000 && pop_req > 0; c++) @(negedge clk);
        check("pop_done", pop_req, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        consume_en = 1;
        for (int c = 0; c < 20000 && exp_q.size() > 0; c++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("drain_ready", ready, 1'b0);
        consume_en = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_overflow", overflow, 1'b0);
        check("rst_sampling", sampling, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        clr = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame: latency, write timing and edge count
        watch_samp = 11;
        send_byte(8'h1C, 0, 0, 0);
        check("start_latency", lat, 3);
        check("ready_in_stop_cycle", rdy_t, 1'b0);
        check("ready_after_stop", rdy_t1, 1'b1);
        check("data_after_stop", data_t1, 8'h1C);
        check("sampling_pulses", samp_cnt, 11);
        check("no_frame_err", err_seen, 0);
        pop_n(1);
        check("empty_after_pop", ready, 1'b0);

        // Two queued frames then two pops
        send_byte(8'hF0, 0, 0, 0);
        send_byte(8'h1C, 0, 0, 0);
        check("two_ready", ready, 1'b1);
        check("two_head", data, 8'hF0);
        pop_n(1);
        check("second_head", data, 8'h1C);
        pop_n(1);
        check("two_drained", ready, 1'b0);
        blind_pop = 1;
        repeat (4) @(negedge clk);
        check("pop_when_empty", ready, 1'b0);

        // Parity error then a good frame
        send_byte(8'h1C, 1, 0, 0);
        check("parity_err", err_seen, err_exp);
        check("parity_err_on_stop_edge", err_samp, 1'b1);
        check("parity_no_write", ready, 1'b0);
        send_byte(8'h32, 0, 0, 0);
        check("after_err_head", data, 8'h32);
        drain();

        // Start bit of 1
        err_exp++;
        ps2_send(11'h7FF, 1);
        check("bad_start_err", err_seen, err_exp);
        check("bad_start_no_write", ready, 1'b0);

        // Overflow with no pops
        for (int i = 0; i < 9; i++) send_byte(8'($urandom), 0, 0, 0);
        check("overflow_set", overflow, ovf_exp);
        check("overflow_is_one", overflow, 1'b1);
        check("overflow_ready", ready, 1'b1);
        pop_n(1);
        check("overflow_cleared", overflow, 1'b0);
        drain();

        // Full FIFO with a pop coinciding with the 9th stop edge
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0, 0, 0);
        pop_at_samp = samp_cnt + 11;
        send_byte(8'($urandom), 0, 0, 1);
        check("coincide_no_overflow", overflow, 1'b0);
        check("coincide_count", exp_q.size(), DEPTH);
        send_byte(8'($urandom), 0, 0, 0);
        check("coincide_still_full", overflow, 1'b1);
        drain();
        check("coincide_ovf_cleared", overflow, 1'b0);

        // Random frames with a live consumer
        consume_en = 1;
        for (int i = 0; i < 12; i++) begin
            bit bp;
            bit bs;
            bp = ($urandom_range(0, 3) == 0);
            bs = !bp && ($urandom_range(0, 4) == 0);
            send_byte(8'($urandom), bp, bs, 0);
        end
        drain();
        check("random_errs", err_seen, err_exp);
        check("random_no_overflow", overflow, 1'b0);

        // Stall after 5 bits
        err_exp++;
        $display("send partial frame then stall");
        ps2_send({6'b0, 4'hA, 1'b0}, 5);
        repeat (TO + 50) @(negedge clk);
        check("timeout_err", err_seen, err_exp);
        check("timeout_no_write", ready, 1'b0);
        send_byte(8'h1C, 0, 0, 0);
        check("after_timeout_head", data, 8'h1C);
        drain();

        // Reset mid-frame with data in the FIFO
        send_byte(8'h55, 0, 0, 0);
        $display("send partial frame then clr");
        ps2_send({6'b0, 4'h5, 1'b0}, 5);
        clr = 1'b1;
        exp_q.delete();
        ovf_exp = 0;
        repeat (2) @(negedge clk);
        check("clr_ready", ready, 1'b0);
        check("clr_data", data, 8'h00);
        check("clr_overflow", overflow, 1'b0);
        check("clr_sampling", sampling, 1'b0);
        check("clr_frame_err", frame_err, 1'b0);
        clr = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'h1C, 0, 0, 0);
        check("after_clr_head", data, 8'h1C);
        drain();
        check("final_errs", err_seen, err_exp);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host receiver with a receive FIFO. Synchronises the raw `ps2_clk`/`ps2_data` pins and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Valid scan codes are queued for the scan-code FSM stage, which pops them through a `ready`/`nextdata_n` handshake. Framing, parity and timeout errors are flagged, and the bad frames are discarded.

## Interface
- `FIFO_DEPTH`, 8: entries in receive FIFO (power of two, ≥2)
- `TIMEOUT_CYCLES`, 20000: `clk` cycles without a `ps2_clk` falling edge mid-frame before the frame is abandoned
- `clk`  in  1  system clock; all logic on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous
- `nextdata_n`  in  1  active-low pop request, one cycle per byte
- `data`  out  8  FIFO head byte, valid while `ready`=1
- `ready`  out  1  FIFO non-empty
- `overflow`  out  1  sticky: a valid frame was dropped because the FIFO was full
- `sampling`  out  1  one-cycle pulse on each synchronised `ps2_clk` falling edge
- `frame_err`  out  1  one-cycle pulse: bad start, stop or parity, or timeout

## Operation
- Synchroniser: 3-flop shift on `ps2_clk` and `ps2_data`. Falling edge = sync[2]=1 & sync[1]=0. The data bit is taken from synchronised `ps2_data` in the same cycle.
- FSM states:
  - IDLE: on an edge, if data=0 go to DATA with bit count 0; if data=1, pulse `frame_err` and stay in IDLE.
  - DATA: on each edge, shift the bit into shreg[7] (right shift); after 8 bits go to PAR.
  - PAR: on an edge, latch the parity bit and go to STOP.
  - STOP: on an edge, check stop=1 and odd parity (^shreg ^ par == 1), then return to IDLE.
- Good frame: write shreg to the FIFO. FIFO full and no pop in the same cycle: drop the frame and set `overflow`.
- Bad frame: pulse `frame_err`, no write.
- Timeout: a counter runs in DATA/PAR/STOP and reloads on each edge. When it reaches TIMEOUT_CYCLES: go to IDLE, pulse `frame_err`, no write.
- Pop: `nextdata_n`=0 while `ready`=1 advances the read pointer. `nextdata_n`=0 while empty is ignored.
- Simultaneous write and pop: both take effect, and the count is unchanged. A write to a full FIFO with a pop in the same cycle succeeds.
- `overflow` clears on the first pop after it was set, or on `clr`.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. The extra MSB distinguishes full from empty.
- Reset mid-frame: partial frame discarded, FSM to IDLE. Synchroniser flops reset to 1.

## Timing
- Reset values: `data`=8'h00 (mem[0] cleared), `ready`=0, `overflow`=0, `sampling`=0, `frame_err`=0. FSM=IDLE, pointers=0, timeout counter=0.
- Pin falling edge to `sampling` pulse: 3 `clk` cycles.
- Stop-bit edge in cycle T (`sampling`=1): FIFO write at end of T; `ready`=1 and `data` valid in T+1. Same timing for `frame_err`, which is asserted in T.
- Pop in cycle P: `data` shows the next entry in P+1. `ready` falls in P+1 if that was the last entry.
- `data` is combinational from memory at the read pointer; there is no extra register stage.
- `overflow` sets in T+1 of the dropped frame.

## Structure
- Package `ps2_pkg`:
  - FSM state enum {IDLE, DATA, PAR, STOP}
  - `PS2_DATA_BITS`=8
  - `PS2_SYNC_STAGES`=3
- Sub-module `ps2_rx_fifo`: synchronous FIFO with write/read enables and full/empty/head outputs, parameterised by FIFO_DEPTH. Deserialiser, synchroniser and timeout stay in `ps2_frame_rx`.

## Test plan
- Frame 0x1C, parity 0, stop 1, ~12.5 kHz `ps2_clk` -> `ready`=1 and `data`=8'h1C one cycle after the stop edge; 11 `sampling` pulses; `frame_err` never set.
- Frames 0xF0 (parity 1) then 0x1C, no pops -> FIFO holds 2. Pop once -> `data` goes F0→1C. Pop again -> `ready`=0.
- 0x1C sent with parity 1 -> `frame_err` pulse in the stop-edge cycle, `ready` stays 0. Next good frame 0x32 is received normally.
- 9 good frames with depth 8 and no pops -> 9th dropped, `overflow`=1. FIFO keeps the first 8. First pop clears `overflow`.
- Full FIFO, 9th stop edge coincides with a pop -> no overflow; FIFO still full with the 9th byte at the tail.
- `ps2_clk` stalls after 5 bits for TIMEOUT_CYCLES -> `frame_err` pulse, FSM back to IDLE, a following 0x1C frame is received correctly. `clr` asserted mid-frame -> all outputs return to reset values.
